// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB register completer.
package apb_pkg;

    typedef enum logic {IDLE, ACCESS} apb_cpl_state_e;

    localparam logic APB_RESP_OKAY = 1'b0;
    localparam logic APB_RESP_ERR  = 1'b1;

    // Word-index width; never below 1 so a single-register bank still has an index bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/apb_reg_array.sv
// Register storage, read-only status mux and per-register write pulses.
module apb_reg_array
    import apb_pkg::*;
#(
    parameter int                  NUM_REGS   = 16,
    parameter int                  DATA_WIDTH = 32,
    parameter int                  IDX_W      = idx_w(NUM_REGS),
    parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_en,
    input  logic [IDX_W-1:0]               wr_idx,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic [IDX_W-1:0]               rd_idx,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_in,
    output logic [DATA_WIDTH-1:0]          rd_data,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            reg_wr_pulse
);

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;

    // RO slots are never written, so their storage stays at the reset value of 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs         <= '0;
            reg_wr_pulse <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                reg_wr_pulse[i] <= wr_en && (wr_idx == IDX_W'(i)) && !RO_MASK[i];
                if (wr_en && (wr_idx == IDX_W'(i)) && !RO_MASK[i])
                    regs[i] <= wr_data;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == IDX_W'(i))
                rd_data = RO_MASK[i] ? ro_in[i*DATA_WIDTH +: DATA_WIDTH] : regs[i];
        end
    end

    assign reg_q = regs;

endmodule

// File: rtl/apb_reg_completer.sv
// APB3 completer: address decode, wait-state counter and response FSM over a register bank.
module apb_reg_completer
    import apb_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0]   RO_MASK     = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_WIDTH-1:0]          S_APB_PADDR,
    input  logic                           S_APB_PSEL,
    input  logic                           S_APB_PENABLE,
    input  logic                           S_APB_PWRITE,
    input  logic [DATA_WIDTH-1:0]          S_APB_PWDATA,
    output logic [DATA_WIDTH-1:0]          S_APB_PRDATA,
    output logic                           S_APB_PREADY,
    output logic                           S_APB_PSLVERR,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            reg_wr_pulse,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_in
);

    localparam int IW = idx_w(NUM_REGS);

    typedef struct packed {
        logic                  err;
        logic                  write;
        logic [IW-1:0]         idx;
        logic [DATA_WIDTH-1:0] wdata;
        logic [DATA_WIDTH-1:0] rdata;
    } xfer_t;

    apb_cpl_state_e        state;
    logic [3:0]            cnt;
    xfer_t                 xfer_q;
    logic                  pready_q, pslverr_q;
    logic [DATA_WIDTH-1:0] prdata_q;

    logic [ADDR_WIDTH-1:0] off, word_off;
    logic                  in_range, dec_err;
    logic [IW-1:0]         dec_idx;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  go_ready, ld_err, ld_rd, wr_en;
    logic [DATA_WIDTH-1:0] ld_rdata;

    // PENABLE carries no information we need: any PSEL seen in IDLE starts a transfer.
    logic unused_penable;
    assign unused_penable = S_APB_PENABLE;

    assign off      = S_APB_PADDR - BASE_ADDR;
    assign word_off = off >> 2;
    assign in_range = (S_APB_PADDR[1:0] == 2'b00) && (S_APB_PADDR >= BASE_ADDR)
                      && (word_off < ADDR_WIDTH'(NUM_REGS));
    assign dec_idx  = word_off[IW-1:0];
    assign dec_err  = !in_range || (S_APB_PWRITE && RO_MASK[dec_idx]);

    // Response source: live decode when completing straight from setup, latched copy otherwise.
    always_comb begin
        if (state == IDLE) begin
            go_ready = S_APB_PSEL && (WAIT_STATES == 0);
            ld_err   = dec_err;
            ld_rd    = !dec_err && !S_APB_PWRITE;
            ld_rdata = rd_data;
        end else begin
            go_ready = S_APB_PSEL && !pready_q && (cnt == 4'd1);
            ld_err   = xfer_q.err;
            ld_rd    = !xfer_q.err && !xfer_q.write;
            ld_rdata = xfer_q.rdata;
        end
    end

    assign wr_en = (state == ACCESS) && pready_q && S_APB_PSEL && xfer_q.write && !xfer_q.err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            xfer_q    <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= APB_RESP_OKAY;
            prdata_q  <= '0;
        end else begin
            pready_q  <= go_ready;
            pslverr_q <= (go_ready && ld_err) ? APB_RESP_ERR : APB_RESP_OKAY;
            prdata_q  <= (go_ready && ld_rd) ? ld_rdata : '0;
            case (state)
                IDLE: begin
                    if (S_APB_PSEL) begin
                        state  <= ACCESS;
                        cnt    <= 4'(WAIT_STATES);
                        xfer_q <= '{err: dec_err, write: S_APB_PWRITE, idx: dec_idx,
                                    wdata: S_APB_PWDATA, rdata: rd_data};
                    end
                end
                ACCESS: begin
                    // Completion cycle or master abort both return to IDLE.
                    if (pready_q || !S_APB_PSEL) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
            endcase
        end
    end

    assign S_APB_PREADY  = pready_q;
    assign S_APB_PSLVERR = pslverr_q;
    assign S_APB_PRDATA  = prdata_q;

    apb_reg_array #(
        .NUM_REGS  (NUM_REGS),
        .DATA_WIDTH(DATA_WIDTH),
        .IDX_W     (IW),
        .RO_MASK   (RO_MASK)
    ) u_regs (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_idx      (xfer_q.idx),
        .wr_data     (xfer_q.wdata),
        .rd_idx      (dec_idx),
        .ro_in       (ro_in),
        .rd_data     (rd_data),
        .reg_q       (reg_q),
        .reg_wr_pulse(reg_wr_pulse)
    );

endmodule

// File: doc/apb_reg_completer.md
Name: apb_reg_completer

Overview:
APB3 completer (slave) that terminates an APB master link such as the M_APB_* port of the bridge blocks. It hosts a bank of 32-bit control/status registers, inserts a configurable number of wait states, and flags decode errors on PSLVERR. Registered contents and per-register write pulses are exposed to core logic. Selected registers are read-only and mirror hardware status inputs.

Parameters:
ADDR_WIDTH, 32, PADDR width.
DATA_WIDTH, 32, PWDATA/PRDATA width; only 32 is supported.
NUM_REGS, 16, number of word registers (1..256).
BASE_ADDR, 32'h0000_0000, byte address of register 0; must be aligned to NUM_REGS*4.
WAIT_STATES, 0, access-phase cycles with PREADY=0 before completion (0..15).
RO_MASK, '0, NUM_REGS-bit mask. Bit i=1 makes register i read-only; it reads ro_in slice i.

Ports:
clk  input  1  single clock.
rst  input  1  synchronous reset, active-high.
S_APB_PADDR  input  ADDR_WIDTH  byte address.
S_APB_PSEL  input  1  select.
S_APB_PENABLE  input  1  access phase.
S_APB_PWRITE  input  1  1=write, 0=read.
S_APB_PWDATA  input  DATA_WIDTH  write data.
S_APB_PRDATA  output  DATA_WIDTH  read data.
S_APB_PREADY  output  1  transfer completion.
S_APB_PSLVERR  output  1  error response.
reg_q  output  NUM_REGS*DATA_WIDTH  current RW register values; register i is at [i*32 +: 32].
reg_wr_pulse  output  NUM_REGS  one-cycle pulse per register on a committed write.
ro_in  input  NUM_REGS*DATA_WIDTH  status values for read-only registers.

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - State is IDLE, wait counter is 0, all RW registers are 0.
  - PREADY=0, PRDATA=0, PSLVERR=0, reg_wr_pulse=0.
- Reset mid-transfer aborts the transfer with no register update and no pulse. The master restarts the transfer.
- FSM states: IDLE, ACCESS.
  - IDLE -> ACCESS when PSEL=1 (setup phase). On this edge: cnt := WAIT_STATES; latch decode, PWRITE, PWDATA and read data.
  - In ACCESS, while cnt != 0: PREADY=0 and cnt decrements each cycle.
  - In ACCESS, when cnt == 0: PREADY=1 for exactly one cycle, then the next state is IDLE.
  - ACCESS with PSEL=0 (master abort): return to IDLE with no write and no pulse.
- Latency:
  - Setup at cycle T gives PREADY=1 at cycle T+1+WAIT_STATES.
  - Back-to-back transfers: a new setup is accepted the cycle after PREADY.
- Decode (at setup):
  - idx = (PADDR - BASE_ADDR) >> 2.
  - Error if PADDR[1:0] != 0, or PADDR < BASE_ADDR, or idx >= NUM_REGS.
  - Error if PWRITE=1 and RO_MASK[idx]=1.
- Outputs:
  - PRDATA is valid only while PREADY=1 with a non-error read. It is 0 in every other cycle, including all writes and errors.
  - PSLVERR=1 only in the PREADY cycle of an erroring transfer; it is 0 otherwise.
  - Read value: reg_q slice idx, or ro_in slice idx if RO_MASK[idx]=1. The value is sampled at setup.
- Writes:
  - A write commits at the clk edge that ends the PREADY=1 cycle, only if there is no error.
  - Register idx takes PWDATA. reg_q and reg_wr_pulse[idx] update on that same edge; the pulse is high for exactly one cycle.
  - An erroring write changes no register and raises no pulse.
- reg_q slices for RO registers are driven 0.
- PENABLE is not required for progress. PSEL with PENABLE=1 seen in IDLE is treated as a setup phase, so the master never hangs.

Decomposition:
- Package apb_pkg holds:
  - typedef enum {IDLE, ACCESS} apb_cpl_state_e;
  - APB_RESP_OKAY / APB_RESP_ERR constants;
  - the word-index width function clog2-based idx_w(NUM_REGS).
- One sub-module, apb_reg_array, holds the register storage, the RO mux and the write-pulse generation. The top level holds the FSM, wait counter and decode.

Test Plan:
1. WAIT_STATES=0, write 32'hDEAD_BEEF to 0x08 then read 0x08 -> PREADY one cycle after each setup; PSLVERR=0; reg_wr_pulse[2] one cycle; PRDATA=32'hDEAD_BEEF.
2. WAIT_STATES=3, read 0x00 after reset -> PREADY low for 3 access cycles, high on the 4th; PRDATA=0.
3. Errors with NUM_REGS=16: read 0x40 (out of range), read 0x06 (misaligned), write to RO reg 1 with ro_in[1]=32'h1234 -> PSLVERR=1 with PRDATA=0 and no pulse for each; a subsequent read of 0x04 returns 32'h1234.
4. Back-to-back writes to 0x00, 0x04, 0x3C with no idle cycles -> three completions; reg_q slices 0, 1 and 15 updated; three single-cycle pulses.
5. rst asserted during the wait of a write (WAIT_STATES=5) -> no register change, PREADY=0; a restarted write completes normally.
6. PSEL dropped mid-wait -> return to IDLE, no write; the next setup is served with full WAIT_STATES latency.
